// File: rtl/round_div_pkg.sv
// Shared types and constants for the round_div_arbiter slice.
// Optional saturation counter is enabled by defining ROUND_DIV_SAT_CNT_EN.
package round_div_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int SAT_CNT_W = 16;

endpackage

// File: rtl/round_div_core.sv
// Combinational divide by 2**DIV_LOG2 with round-half-up and all-ones saturation.
module round_div_core #(
    parameter int DIV_LOG2  = 3,
    parameter int OUT_WIDTH = 32
) (
    input  logic [OUT_WIDTH+DIV_LOG2-1:0] din,
    output logic [OUT_WIDTH-1:0]          dout,
    output logic                          sat
);

    logic [OUT_WIDTH-1:0] q;
    logic [OUT_WIDTH:0]   r;

    always_comb begin
        q    = OUT_WIDTH'(din >> DIV_LOG2);
        r    = {1'b0, q} + {{OUT_WIDTH{1'b0}}, din[DIV_LOG2-1]};
        sat  = r[OUT_WIDTH];
        // On overflow q is already all-ones, so it doubles as the saturated value.
        dout = sat ? q : r[OUT_WIDTH-1:0];
    end

endmodule

// File: rtl/round_div_arbiter.sv
// Round-robin arbiter feeding one shared rounding divider into a single result register.
// Define ROUND_DIV_SAT_CNT_EN to add the 16-bit sat_count output.
module round_div_arbiter
    import round_div_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DIV_LOG2  = 3,
    parameter int OUT_WIDTH = 32,
    parameter int IN_WIDTH  = OUT_WIDTH + DIV_LOG2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*IN_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    output logic [OUT_WIDTH-1:0]          out_data,
    output logic [$clog2(NUM_REQ)-1:0]    out_id,
    input  logic                          out_ready
`ifdef ROUND_DIV_SAT_CNT_EN
    ,
    output logic [SAT_CNT_W-1:0]          sat_count
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int CW   = OUT_WIDTH + DIV_LOG2;

    state_t               state;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      grant;
    logic [ID_W-1:0]      grant_next;
    logic                 found;
    logic                 can_accept;
    logic                 accept;
    logic [IN_WIDTH-1:0]  grant_data;
    logic [CW-1:0]        din;
    logic [OUT_WIDTH-1:0] result;
    logic                 sat;

    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        grant = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                grant = ID_W'(idx);
            end
        end
    end

    // Reset clears state asynchronously, so gate explicitly to keep req_ready low during reset.
    assign can_accept = !reset && ((state == EMPTY) || out_ready);
    assign accept     = can_accept && found;
    assign req_ready  = accept ? (NUM_REQ'(1) << grant) : '0;
    assign grant_next = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
    assign grant_data = req_data[int'(grant)*IN_WIDTH +: IN_WIDTH];

    generate
        if (IN_WIDTH >= CW) begin : g_din_trunc
            assign din = grant_data[CW-1:0];
        end else begin : g_din_pad
            assign din = {{(CW-IN_WIDTH){1'b0}}, grant_data};
        end
    endgenerate

    round_div_core #(
        .DIV_LOG2  (DIV_LOG2),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_core (
        .din  (din),
        .dout (result),
        .sat  (sat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            out_data <= '0;
            out_id   <= '0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state    <= FULL;
                        out_data <= result;
                        out_id   <= grant;
                        rr_ptr   <= grant_next;
                    end
                end
                FULL: begin
                    if (accept) begin
                        out_data <= result;
                        out_id   <= grant;
                        rr_ptr   <= grant_next;
                    end else if (out_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign out_valid = (state == FULL);

`ifdef ROUND_DIV_SAT_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_count <= '0;
        end else if (accept && sat && (sat_count != '1)) begin
            sat_count <= sat_count + SAT_CNT_W'(1);
        end
    end
`else
    logic unused_sat;
    assign unused_sat = sat;
`endif

endmodule

// File: tb/tb_round_div_arbiter.sv
// Self-checking bench for round_div_arbiter: directed cases plus randomized traffic
// compared against an arithmetic reference model of divider and round-robin arbiter.
module tb_round_div_arbiter;

    localparam int N     = 4;
    localparam int DL2   = 3;
    localparam int OW    = 32;
    localparam int IW    = OW + DL2;
    localparam int IDW   = $clog2(N);

    logic            clk;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*IW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [OW-1:0]   out_data;
    logic [IDW-1:0]  out_id;
    logic            out_ready;
`ifdef ROUND_DIV_SAT_CNT_EN
    logic [15:0]     sat_count;
`endif

    int n_checks;
    int n_errors;

    // reference model state
    bit          m_full;
    longint      m_data;
    int          m_id;
    int          m_ptr;
    int          m_sat;

    round_div_arbiter #(
        .NUM_REQ   (N),
        .DIV_LOG2  (DL2),
        .OUT_WIDTH (OW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
`ifdef ROUND_DIV_SAT_CNT_EN
        ,
        .sat_count (sat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Round-half-up divide by 8, saturating to 32 bits.
    function automatic longint ref_div(input longint din, output bit sat);
        longint q;
        longint r;
        q   = din / 8;
        r   = q + (((din % 8) >= 4) ? 1 : 0);
        sat = (r > 64'hFFFF_FFFF);
        return sat ? 64'hFFFF_FFFF : r;
    endfunction

    task automatic model_reset();
        m_full = 0;
        m_data = 0;
        m_id   = 0;
        m_ptr  = 0;
        m_sat  = 0;
    endtask

    task automatic set_data(input int id, input longint v);
        req_data[id*IW +: IW] = v[IW-1:0];
    endtask

    // One clock: check req_ready before the edge, advance model, check outputs after it.
    task automatic cycle();
        bit     can;
        bit     found;
        bit     sat;
        int     g;
        longint din;
        logic [N-1:0] exp_ready;
        #1;
        can   = !m_full || out_ready;
        found = 0;
        g     = 0;
        for (int i = 0; i < N; i++) begin
            if (!found && req_valid[(m_ptr + i) % N]) begin
                found = 1;
                g     = (m_ptr + i) % N;
            end
        end
        exp_ready = (can && found) ? N'(1 << g) : '0;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        if (can && found) begin
            din    = longint'(req_data[g*IW +: IW]);
            m_data = ref_div(din, sat);
            m_full = 1;
            m_id   = g;
            m_ptr  = (g + 1) % N;
            if (sat && m_sat < 16'hFFFF) m_sat++;
        end else if (m_full && out_ready) begin
            m_full = 0;
        end
        @(posedge clk);
        #1;
        check("out_valid", 64'(out_valid), 64'(m_full));
        check("out_data", 64'(out_data), 64'(m_data));
        check("out_id", 64'(out_id), 64'(m_id));
`ifdef ROUND_DIV_SAT_CNT_EN
        check("sat_count", 64'(sat_count), 64'(m_sat));
`endif
    endtask

    task automatic send_one(input int id, input longint v);
        req_valid = '0;
        req_valid[id] = 1'b1;
        set_data(id, v);
        out_ready = 1'b1;
        cycle();
        req_valid = '0;
    endtask

    initial begin
        int order[5];
        int pick;
        longint v;
        order = '{0, 1, 2, 3, 0};
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b1;
        model_reset();

        // reset state, with requests present
        @(posedge clk);
        @(posedge clk);
        #1;
        req_valid = '1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_id", 64'(out_id), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        reset = 1'b0;

        // rounding cases
        send_one(0, 20);
        check("d20_data", 64'(out_data), 64'd3);
        check("d20_id", 64'(out_id), 64'd0);
        send_one(0, 19);
        check("d19_data", 64'(out_data), 64'd2);
        send_one(0, 4);
        check("d4_data", 64'(out_data), 64'd1);
        send_one(0, 3);
        check("d3_data", 64'(out_data), 64'd0);
        send_one(0, 64'h7_FFFF_FFFF);
        check("dmax_data", 64'(out_data), 64'hFFFF_FFFF);
`ifdef ROUND_DIV_SAT_CNT_EN
        check("dmax_satcnt", 64'(sat_count), 64'd1);
`endif

        // drain with no request, then realign pointer to 0 via requester 3
        cycle();
        check("drain_empty", 64'(out_valid), 64'd0);
        send_one(3, 100);
        check("r3_id", 64'(out_id), 64'd3);

        // all four valid: 0,1,2,3,0 back-to-back
        for (int i = 0; i < N; i++) set_data(i, longint'(8 * (i + 1)));
        req_valid = '1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("rr_order", 64'(out_id), 64'(order[k]));
            check("rr_valid", 64'(out_valid), 64'd1);
        end

        // stall 3 cycles while FULL, then drain and accept together
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("stall_ready", 64'(req_ready), 64'd0);
            check("stall_id", 64'(out_id), 64'd0);
            check("stall_data", 64'(out_data), 64'd1);
        end
        out_ready = 1'b1;
        cycle();
        check("resume_id", 64'(out_id), 64'd1);
        check("resume_data", 64'(out_data), 64'd2);

        // asynchronous reset while FULL
        #3;
        reset = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_data", 64'(out_data), 64'd0);
        check("arst_ready", 64'(req_ready), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle();
        check("post_rst_id", 64'(out_id), 64'd0);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            req_valid = N'($urandom_range(0, (1 << N) - 1));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                pick = $urandom_range(0, 3);
                case (pick)
                    0: v = longint'($urandom_range(0, 255));
                    1: v = {29'd0, 3'($urandom), 32'($urandom)};
                    2: v = 64'h7_FFFF_FFF8 + longint'($urandom_range(0, 7));
                    default: v = longint'($urandom);
                endcase
                set_data(i, v);
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/round_div_arbiter.md
ROUND_DIV_ARBITER -- requirements
Module: round_div_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, the number of requesters sharing one rounding divider (2..16).
REQ-002 The block SHALL have parameter DIV_LOG2, default 3, giving a divisor of 2**DIV_LOG2 (at least 1).
REQ-003 The block SHALL have parameter OUT_WIDTH, default 32, the quotient width.
REQ-004 The block SHALL have parameter IN_WIDTH, default OUT_WIDTH+DIV_LOG2, the dividend width.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-007 The block SHALL have port req_valid, input, NUM_REQ bits; bit i means requester i presents a dividend.
REQ-008 The block SHALL have port req_data, input, NUM_REQ*IN_WIDTH bits; slice i is the dividend of requester i.
REQ-009 The block SHALL have port req_ready, output, NUM_REQ bits, a one-hot or zero acceptance strobe.
REQ-010 The block SHALL have port out_valid, output, 1 bit, meaning the result register holds data.
REQ-011 The block SHALL have port out_data, output, OUT_WIDTH bits, the rounded and saturated quotient.
REQ-012 The block SHALL have port out_id, output, $clog2(NUM_REQ) bits, the requester index of out_data.
REQ-013 The block SHALL have port out_ready, input, 1 bit, the downstream acceptance.

Function
REQ-014 The divide SHALL be: q = din >> DIV_LOG2, r = q + din[DIV_LOG2-1], computed at OUT_WIDTH+1 bits.
REQ-015 If r overflows OUT_WIDTH bits, the result SHALL be q, which is all-ones saturation; otherwise the result SHALL be r[OUT_WIDTH-1:0].
REQ-016 The block SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 The block SHALL be able to accept ("can_accept") when in EMPTY, or when in FULL with out_ready=1 in the same cycle.
REQ-018 Grant SHALL be round-robin: the lowest index at or after rr_ptr, wrapping modulo NUM_REQ, whose req_valid is 1.
REQ-019 req_ready[g] SHALL be 1 only when can_accept is true and g is the granted index; every other req_ready bit SHALL be 0.
REQ-020 On acceptance, the result and g SHALL be registered into out_data/out_id on the next edge, with latency 1 cycle, and the state SHALL be FULL.
REQ-021 On acceptance, rr_ptr SHALL become g+1, wrapping from NUM_REQ-1 to 0; rr_ptr SHALL NOT change when no acceptance occurs.
REQ-022 In FULL with out_ready=0, out_valid, out_data and out_id SHALL hold stable.
REQ-023 Drain and accept in the same cycle SHALL give back-to-back results at full throughput, one per cycle.
REQ-024 A drain with no request present SHALL move the state FULL->EMPTY.
REQ-025 A requester SHALL NOT be granted twice while another requester holds req_valid=1 (starvation-free).
REQ-026 The req_ready outputs SHALL be combinational from req_valid, rr_ptr, state and out_ready, and SHALL NOT depend on req_data.

Reset
REQ-027 Asserting reset at any time, including while FULL, SHALL set out_valid=0, out_data=0, out_id=0, rr_ptr=0 and state EMPTY; any held result SHALL be discarded.
REQ-028 While reset is asserted, req_ready SHALL be all zeros.

Configuration
REQ-029 With macro ROUND_DIV_SAT_CNT_EN defined, the block SHALL add output port sat_count, 16 bits, which increments on each accepted dividend that takes the saturation path of REQ-015.
REQ-030 sat_count SHALL saturate at 0xFFFF and SHALL reset to 0.
REQ-031 Without ROUND_DIV_SAT_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-032 Package round_div_pkg SHALL hold the state typedef (EMPTY, FULL) and the SAT_CNT_W=16 constant.
REQ-033 The divide of REQ-014/015 SHALL be the combinational sub-module round_div_core, parameterised by DIV_LOG2 and OUT_WIDTH, with an additional sat output flag.

Verification
REQ-034 The bench SHALL cover: dividend 20 from requester 0, out_ready=1 -> out_data=3, out_id=0 one cycle later.
REQ-035 The bench SHALL cover: dividend 19 -> out_data 2; dividend 4 -> out_data 1; dividend 3 -> out_data 0.
REQ-036 The bench SHALL cover: dividend 0x7_FFFF_FFFF, all ones -> out_data 0xFFFFFFFF, and sat_count increments by 1 when the macro is enabled.
REQ-037 The bench SHALL cover: all four requesters held valid with out_ready=1 -> grant order 0,1,2,3,0, one result per cycle.
REQ-038 The bench SHALL cover: out_ready=0 for 3 cycles while FULL -> outputs stable and req_ready all 0; then out_ready=1 -> drain and next accept in the same cycle.
REQ-039 The bench SHALL cover: reset asserted mid-stream while FULL -> out_valid=0 immediately (asynchronous), and after release requester 0 is granted first.
